// File: rtl/display_scan_controller.sv
// Digit scan sequencer for the coffee machine 7-segment display.
// Produces the digit index, active-low digit enables, a blanking flag and
// the error-message select, with a one-cycle acknowledge on error exit.
// Build option: define DISPLAY_SCAN_BLINK_EN to blink the error message;
// without it the error message is shown steadily.
module display_scan_controller #(
  parameter int PRESCALE    = 50000,
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_SLOTS = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       error_req,
  input  logic       error_clear,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_en,
  output logic       blank,
  output logic       err_mode,
  output logic       error_ack
);

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0]    DG_LAST = 2'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SCAN,
    ST_ERR_ON,
    ST_ERR_OFF
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    digit_reg, digit_next;
  logic          tick;
  logic          blink_flip;
  logic          ack_next;
  logic          blank_next;
  logic          err_next;
  logic [3:0]    en_next;

  logic [3:0]    digit_en_reg;
  logic          blank_reg;
  logic          err_mode_reg;
  logic          error_ack_reg;

  // End of a digit slot; the prescaler only runs while the display is on
  always_comb begin
    tick = (state_reg != ST_OFF) && (presc_reg == PS_LAST);
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int            BW      = $clog2(BLINK_SLOTS + 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_SLOTS - 1);

  logic [BW-1:0] blink_reg, blink_next;

  // Last slot of a blink half-period: toggle ERR_ON/ERR_OFF
  always_comb begin
    blink_flip = tick && (blink_reg == BL_LAST);
  end

  // Blink slot counter; restarts whenever error mode is (re)entered or left
  always_comb begin
    blink_next = blink_reg;
    if ((state_next == ST_ERR_ON || state_next == ST_ERR_OFF) &&
        (state_reg == ST_ERR_ON || state_reg == ST_ERR_OFF)) begin
      if (tick) begin
        blink_next = blink_flip ? '0 : blink_reg + 1'b1;
      end
    end else begin
      blink_next = '0;
    end
  end

  // Blink counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_reg <= '0;
    end else begin
      blink_reg <= blink_next;
    end
  end
`else
  logic unused_blink_cfg;

  // Steady error message: never toggle to the blanked half
  always_comb begin
    blink_flip       = 1'b0;
    unused_blink_cfg = (BLINK_SLOTS > 0);
  end
`endif

  // Next-state and acknowledge logic; enable=0 dominates, then error exit
  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    case (state_reg)
      ST_OFF: begin
        if (enable) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable)        state_next = ST_OFF;
        else if (error_req) state_next = ST_ERR_ON;
      end
      ST_ERR_ON, ST_ERR_OFF: begin
        if (!enable) begin
          state_next = ST_OFF;
        end else if (error_clear && !error_req) begin
          state_next = ST_SCAN;
          ack_next   = 1'b1;
        end else if (blink_flip) begin
          state_next = (state_reg == ST_ERR_ON) ? ST_ERR_OFF : ST_ERR_ON;
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Prescaler and digit index; both parked at 0 whenever the display is off
  always_comb begin
    presc_next = presc_reg;
    digit_next = digit_reg;
    if (state_next == ST_OFF) begin
      presc_next = '0;
      digit_next = '0;
    end else if (state_reg != ST_OFF) begin
      if (tick) begin
        presc_next = '0;
        digit_next = (digit_reg == DG_LAST) ? 2'd0 : digit_reg + 2'd1;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end
  end

  // Output decode from next-state values so every output flop updates together
  always_comb begin
    blank_next = (state_next == ST_OFF) || (state_next == ST_ERR_OFF);
    err_next   = (state_next == ST_ERR_ON) || (state_next == ST_ERR_OFF);
  end

  // Active-low enables; unpopulated digit positions stay off
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en
      localparam logic [1:0] IDX = 2'(gi);
      assign en_next[gi] = blank_next || (gi >= NUM_DIGITS) || (digit_next != IDX);
    end
  endgenerate

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_OFF;
      presc_reg     <= '0;
      digit_reg     <= '0;
      digit_en_reg  <= 4'b1111;
      blank_reg     <= 1'b1;
      err_mode_reg  <= 1'b0;
      error_ack_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      digit_reg     <= digit_next;
      digit_en_reg  <= en_next;
      blank_reg     <= blank_next;
      err_mode_reg  <= err_next;
      error_ack_reg <= ack_next;
    end
  end

  assign digit_sel = digit_reg;
  assign digit_en  = digit_en_reg;
  assign blank     = blank_reg;
  assign err_mode  = err_mode_reg;
  assign error_ack = error_ack_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (PRESCALE=4, 4 digits,
// BLINK_SLOTS=2). Expected output words are queued as stimulus is applied
// and compared one cycle later; directed constant checks cover key points.
module tb_display_scan_controller;

  localparam int P  = 4;
  localparam int ND = 4;
  localparam int BS = 2;
`ifdef DISPLAY_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       error_req = 1'b0;
  logic       error_clear = 1'b0;
  logic [1:0] digit_sel;
  logic [3:0] digit_en;
  logic       blank;
  logic       err_mode;
  logic       error_ack;

  display_scan_controller #(
    .PRESCALE(P),
    .NUM_DIGITS(ND),
    .BLINK_SLOTS(BS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .error_req(error_req),
    .error_clear(error_clear),
    .digit_sel(digit_sel),
    .digit_en(digit_en),
    .blank(blank),
    .err_mode(err_mode),
    .error_ack(error_ack)
  );

  always #5 clk = ~clk;

  // {digit_sel, digit_en, blank, err_mode, error_ack}
  logic [8:0] dut_vec;
  assign dut_vec = {digit_sel, digit_en, blank, err_mode, error_ack};

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  // Reference model state: 0=OFF 1=SCAN 2=ERR_ON 3=ERR_OFF
  int   m_st = 0, m_cnt = 0, m_dig = 0, m_bl = 0;
  logic m_ack = 1'b0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (sel,en,blank,err,ack)", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_out();
    logic       b;
    logic       e;
    logic [3:0] en;
    logic [1:0] d;
    b  = (m_st == 0) || (m_st == 3);
    e  = (m_st >= 2);
    d  = 2'(m_dig);
    en = 4'b1111;
    if (!b) en[d] = 1'b0;
    return {d, en, b, e, m_ack};
  endfunction

  // One clock of the behavioural model
  function automatic void model_step(input logic r, input logic en, input logic er, input logic ec);
    int  ns;
    bit  tk;
    if (r) begin
      m_st = 0; m_cnt = 0; m_dig = 0; m_bl = 0; m_ack = 1'b0;
      return;
    end
    tk    = (m_st != 0) && (m_cnt == P - 1);
    ns    = m_st;
    m_ack = 1'b0;
    case (m_st)
      0: if (en) ns = 1;
      1: if (!en) ns = 0; else if (er) ns = 2;
      default: begin
        if (!en) ns = 0;
        else if (ec && !er) begin ns = 1; m_ack = 1'b1; end
        else if (BLINK && tk && m_bl == BS - 1) ns = (m_st == 2) ? 3 : 2;
      end
    endcase
    if (ns == 0) begin
      m_cnt = 0; m_dig = 0;
    end else if (m_st != 0) begin
      if (tk) begin m_cnt = 0; m_dig = (m_dig + 1) % ND; end
      else m_cnt++;
    end
    if (ns >= 2 && m_st >= 2) begin
      if (tk) m_bl = (m_bl == BS - 1) ? 0 : m_bl + 1;
    end else begin
      m_bl = 0;
    end
    m_st = ns;
  endfunction

  // Apply one cycle of stimulus, queue the prediction, compare after the edge
  task automatic drive(input logic r, input logic en, input logic er, input logic ec, input string tag);
    logic [8:0] e;
    string      t;
    @(negedge clk);
    reset = r; enable = en; error_req = er; error_clear = ec;
    model_step(r, en, er, ec);
    exp_q.push_back(model_out());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, dut_vec, e);
  endtask

  logic [3:0] en_tbl [5];
  logic [1:0] sel_tbl[5];
  logic       r_er;

  initial begin
    en_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    sel_tbl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // 1. reset then enable; digit walk every PRESCALE cycles
    repeat (3) drive(1, 0, 0, 0, "reset");
    check("reset_state", dut_vec, 9'b00_1111_1_0_0);
    drive(0, 1, 0, 0, "enable");
    check("first_digit", dut_vec, 9'b00_1110_0_0_0);
    for (int k = 1; k < 5; k++) begin
      repeat (P) drive(0, 1, 0, 0, "scan");
      check($sformatf("digit%0d", k), dut_vec, {sel_tbl[k], en_tbl[k], 3'b000});
    end

    // 3. raise error in SCAN
    drive(0, 1, 1, 0, "err_enter");
    check("err_mode_on", {7'd0, blank, err_mode}, 9'b0_01);
    repeat (20) drive(0, 1, 1, 0, "err_run");

    // 4. clear while error still requested is ignored
    drive(0, 1, 1, 1, "clear_ignored");
    check("clear_ignored_ack", {7'd0, err_mode, error_ack}, 9'b0_10);

    // 5. drop the request (error stays latched), then clear
    repeat (3) drive(0, 1, 0, 0, "err_latched");
    check("latched", {8'd0, err_mode}, 9'd1);
    drive(0, 1, 0, 1, "err_exit");
    check("exit_ack", {6'd0, blank, err_mode, error_ack}, 9'b001);
    drive(0, 1, 0, 0, "post_exit");
    check("ack_one_cycle", {8'd0, error_ack}, 9'd0);
    drive(0, 1, 0, 1, "clear_in_scan");

    // 6. disable during error mode, then re-enable with error pending
    drive(0, 1, 1, 0, "err_enter2");
    repeat (10) drive(0, 1, 1, 0, "err_run2");
    drive(0, 0, 1, 0, "disable");
    check("disable_state", dut_vec, 9'b00_1111_1_0_0);
    drive(0, 1, 1, 0, "reenable");
    check("reenable_scan", {7'd0, blank, err_mode}, 9'b0_00);
    drive(0, 1, 1, 0, "reenter_err");
    check("reenter_err", {8'd0, err_mode}, 9'd1);
    drive(0, 1, 0, 1, "exit2");
    repeat (6) drive(0, 1, 0, 0, "scan2");
    drive(1, 1, 0, 0, "mid_reset");
    check("mid_reset_state", dut_vec, 9'b00_1111_1_0_0);

    // Random traffic against the model
    r_er = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) r_er = ~r_er;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0), r_er,
            ($urandom_range(0, 9) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
